// File: rtl/mux_reg_8x8.sv
// Byte-wide page register bank: eight entries with per-entry loads, a select-driven
// read mux and a full-bank serial scan chain (TD -> R[0][0] ... R[7][7] -> TQ).
module mux_reg_8x8 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int SEL_W  = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [DEPTH-1:0]  EN_IN,
  input  logic [SEL_W-1:0]  EN_OUT,
  output logic [DATA_W-1:0] OUT,
  input  logic              TC,
  input  logic              TD,
  output logic              TQ
);

  logic [DATA_W-1:0] r [DEPTH];

  // Priority: reset, then scan shift (suppresses every load), then per-entry loads.
  // In scan mode each entry shifts toward its MSB; its LSB is fed from the previous
  // entry's MSB, so the chain runs R[0] first and R[DEPTH-1] last.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r[i] <= '0;
    end else if (TC) begin
      r[0] <= {r[0][DATA_W-2:0], TD};
      for (int i = 1; i < DEPTH; i++) r[i] <= {r[i][DATA_W-2:0], r[i-1][DATA_W-1]};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (EN_IN[i]) r[i] <= IN;
      end
    end
  end

  // Read path is from the registers only; a same-cycle write is seen after the edge.
  assign OUT = r[EN_OUT];
  assign TQ  = r[DEPTH-1][DATA_W-1];

endmodule

// File: tb/tb_mux_reg_8x8.sv
// Self-checking bench for mux_reg_8x8: table-driven load/readback, hand-written
// reset/scan/priority/same-cycle sequences and a randomized run against a bank model.
module tb_mux_reg_8x8;

  logic       CLK;
  logic       RESET;
  logic [7:0] IN;
  logic [7:0] EN_IN;
  logic [2:0] EN_OUT;
  logic [7:0] OUT;
  logic       TC;
  logic       TD;
  logic       TQ;

  mux_reg_8x8 dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .EN_IN(EN_IN), .EN_OUT(EN_OUT),
    .OUT(OUT), .TC(TC), .TD(TD), .TQ(TQ)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // The bank is a byte array; scan treats the whole bank as one 64-bit number
  // whose bit (8*i + j) is R[i][j], and one shift is "times two plus TD".
  logic [7:0] m [8];
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];

  function automatic logic [63:0] model_chain();
    logic [63:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c | (64'(m[i]) << (8 * i));
    return c;
  endfunction

  task automatic model_edge();
    logic [63:0] c;
    if (RESET) begin
      for (int i = 0; i < 8; i++) m[i] = 8'h00;
    end else if (TC) begin
      c = (model_chain() << 1) | 64'(TD);
      for (int i = 0; i < 8; i++) m[i] = 8'((c >> (8 * i)) & 64'hFF);
    end else begin
      for (int i = 0; i < 8; i++) if (EN_IN[i]) m[i] = IN;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic tc, input logic td,
                       input logic [7:0] en, input logic [7:0] din);
    RESET = rst; TC = tc; TD = td; EN_IN = en; IN = din;
  endtask

  // Model the edge from the driven inputs, then let the DUT take it; sample 1 after.
  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Queue the model's view of every entry, then sweep EN_OUT and pop-compare.
  task automatic sweep(input string name);
    for (int e = 0; e < 8; e++) exp_q.push_back(m[e]);
    for (int e = 0; e < 8; e++) begin
      EN_OUT = 3'(e);
      #1;
      check8($sformatf("%s[%0d]", name, e), OUT, exp_q.pop_front());
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [7:0] en_in;
    logic [7:0] din;
    logic [2:0] sel;
    logic [7:0] exp_out;
    logic       exp_tq;
  } vec_t;
  vec_t vecs [16];

  localparam logic [63:0] SCAN_PAT = 64'h0123456789ABCDEF;
  logic [7:0] old_val;

  initial begin
    // Loads of 0x10+i one entry at a time, then a hold-only read sweep.
    for (int i = 0; i < 8; i++) begin
      vecs[i]     = '{en_in: 8'(1 << i), din: 8'(8'h10 + i), sel: 3'(i), exp_out: 8'(8'h10 + i), exp_tq: 1'b0};
      vecs[8 + i] = '{en_in: 8'h00,       din: 8'hFF,         sel: 3'(7 - i), exp_out: 8'(8'h17 - i), exp_tq: 1'b0};
    end

    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    EN_OUT = 3'd0;
    tick(); tick();

    // Reset: preload 0xFF everywhere, then one reset cycle.
    drive(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF); tick();
    check1("preload_tq", TQ, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00); tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int e = 0; e < 8; e++) begin
      EN_OUT = 3'(e); #1;
      check8($sformatf("reset_out[%0d]", e), OUT, 8'h00);
    end
    check1("reset_tq", TQ, 1'b0);

    // Table-driven per-entry load and readback.
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, 1'b0, vecs[k].en_in, vecs[k].din);
      EN_OUT = vecs[k].sel;
      tick();
      check8($sformatf("vec%0d_out", k), OUT, vecs[k].exp_out);
      check1($sformatf("vec%0d_tq", k), TQ, vecs[k].exp_tq);
    end

    // Multi-enable load, then three hold cycles with IN=0xFF.
    drive(1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C); tick();
    sweep("multi_en");
    EN_OUT = 3'd1; #1; check8("multi_en_keep1", OUT, 8'h11);
    EN_OUT = 3'd7; #1; check8("multi_en_load7", OUT, 8'h3C);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
    tick(); tick(); tick();
    sweep("hold");

    // Scan: the last bit shifted lands in R[0][0], so feeding the pattern from
    // bit 63 down leaves the bank holding it with R[0]=0xEF and R[7]=0x01.
    // A parallel load of 0xAA to every entry is held on throughout and must be ignored.
    for (int k = 63; k >= 0; k--) begin
      drive(1'b0, 1'b1, SCAN_PAT[k], 8'hFF, 8'hAA);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    EN_OUT = 3'd0; #1; check8("scan_r0", OUT, 8'hEF);
    EN_OUT = 3'd7; #1; check8("scan_r7", OUT, 8'h01);
    EN_OUT = 3'd3; #1; check8("scan_r3", OUT, 8'h89);
    sweep("scan_bank");
    for (int k = 0; k < 64; k++) begin
      check1($sformatf("scan_tq%0d", k), TQ, SCAN_PAT[63 - k]);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    sweep("scan_flushed");

    // Priority: reset beats scan and load.
    drive(1'b0, 1'b0, 1'b0, 8'hFF, 8'h77); tick();
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'h55); tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int e = 0; e < 8; e++) begin
      EN_OUT = 3'(e); #1;
      check8($sformatf("rst_prio[%0d]", e), OUT, 8'h00);
    end
    // Scan beats load: a cleared bank shifted once with TD=1 gives R[0]=0x01.
    drive(1'b0, 1'b1, 1'b1, 8'h01, 8'hAA); tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    EN_OUT = 3'd0; #1; check8("scan_prio_r0", OUT, 8'h01);
    sweep("scan_prio");

    // Same-cycle read/write of entry 3: old value before the edge, new after.
    drive(1'b0, 1'b0, 1'b0, 8'h08, 8'hC3); tick();
    EN_OUT = 3'd3;
    drive(1'b0, 1'b0, 1'b0, 8'h08, 8'h5A);
    #1;
    old_val = m[3];
    check8("rw_before", OUT, old_val);
    check8("rw_before_const", OUT, 8'hC3);
    tick();
    check8("rw_after", OUT, 8'h5A);

    // Randomized run: rare reset, scan bursts, multi-enable loads, reselects.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      EN_OUT = 3'($urandom_range(0, 7));
      tick();
      check8($sformatf("rand%0d_out", n), OUT, m[EN_OUT]);
      check1($sformatf("rand%0d_tq", n), TQ, m[7][7]);
      EN_OUT = 3'($urandom_range(0, 7));
      #1;
      check8($sformatf("rand%0d_resel", n), OUT, m[EN_OUT]);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    sweep("rand_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
